// File: rtl/md_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_pkg                                                                     |
// | Shared encodings for the multiply/divide sequencer.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/md_div_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_div_iter                                                                |
// | Restoring divider on operand magnitudes, one quotient bit per clock.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module md_div_iter
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int STEP_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_quo;
  logic [WIDTH-1:0]  r_dvs;
  logic              r_negQ;
  logic              r_negR;
  logic              r_dbz;
  logic [STEP_W-1:0] r_steps;
  logic [WIDTH-1:0]  w_absA;
  logic [WIDTH-1:0]  w_absB;
  logic [WIDTH:0]    w_trial;

  assign w_absA  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_absB  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  // Borrow out of the top bit means the shifted partial remainder is below the divisor.
  assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_negQ  <= 1'b0;
      r_negR  <= 1'b0;
      r_dbz   <= 1'b0;
      r_steps <= '0;
    end else if (start) begin
      r_rem   <= '0;
      r_quo   <= w_absA;
      r_dvs   <= w_absB;
      r_negQ  <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_negR  <= is_signed & dividend[WIDTH-1];
      r_dbz   <= (divisor == '0);
      r_steps <= STEP_W'(WIDTH);
    end else if (r_steps != '0) begin
      r_steps <= r_steps - 1'b1;
      if (!w_trial[WIDTH]) begin
        r_rem <= w_trial[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // With a zero divisor the remainder path reproduces the dividend unchanged.
  assign quotient  = r_dbz ? '1 : (r_negQ ? -r_quo : r_quo);
  assign remainder = r_negR ? -r_rem : r_rem;
  assign dbz       = r_dbz;

endmodule
`default_nettype wire

// File: rtl/md_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_sequencer                                                               |
// | Shared multiply/divide sequencer with HI/LO write strobe and ID stall.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module md_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH    = MD_WIDTH,
  parameter int MULT_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [1:0]       issue_op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             hilo_rd,
  input  logic             hilo_wr,
  output logic             md_busy,
  output logic             md_stall,
  output logic             md_done,
  output logic [WIDTH-1:0] md_hi,
  output logic [WIDTH-1:0] md_lo,
  output logic             md_dbz
);

  localparam int CNT_W = $clog2((WIDTH > MULT_LAT) ? WIDTH : MULT_LAT);

  md_state_e          r_state;
  md_state_e          w_stateNext;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] w_prod;
  logic               r_isDiv;
  logic               w_accept;
  logic               w_signExt;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_dbz;

  assign w_accept  = issue_valid & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_signExt = ~issue_op[0];
  // Extending both operands to 2*WIDTH gives the signed or unsigned product in one multiplier.
  assign w_prod = {{WIDTH{w_signExt & opa[WIDTH-1]}}, opa} *
                  {{WIDTH{w_signExt & opb[WIDTH-1]}}, opb};

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (issue_valid) w_stateNext = issue_op[1] ? ST_DIV : ST_MUL;
        else             w_stateNext = ST_IDLE;
      end
      ST_MUL, ST_DIV: begin
        if (r_count == '0) w_stateNext = ST_DONE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_prod  <= '0;
      r_isDiv <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_count <= issue_op[1] ? CNT_W'(WIDTH - 1) : CNT_W'(MULT_LAT - 1);
        r_isDiv <= issue_op[1];
        if (!issue_op[1]) r_prod <= w_prod;
      end else if (md_busy && (r_count != '0)) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  md_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_accept & issue_op[1]),
    .dividend (opa),
    .divisor  (opb),
    .is_signed(~issue_op[0]),
    .quotient (w_quo),
    .remainder(w_rem),
    .dbz      (w_dbz)
  );

  assign md_busy  = (r_state == ST_MUL) | (r_state == ST_DIV);
  assign md_stall = md_busy & (issue_valid | hilo_rd | hilo_wr);
  assign md_done  = (r_state == ST_DONE);
  assign md_hi    = md_done ? (r_isDiv ? w_rem : r_prod[2*WIDTH-1:WIDTH]) : '0;
  assign md_lo    = md_done ? (r_isDiv ? w_quo : r_prod[WIDTH-1:0]) : '0;
  assign md_dbz   = md_done & r_isDiv & w_dbz;

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_md_sequencer                                                            |
// | Scoreboard bench: driver queues expected HI/LO/dbz, monitor checks strobes.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_md_sequencer;
  import md_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         issue_valid = 1'b0;
  logic [1:0]   issue_op = 2'b00;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         hilo_rd = 1'b0;
  logic         hilo_wr = 1'b0;
  logic         md_busy, md_stall, md_done, md_dbz;
  logic [W-1:0] md_hi, md_lo;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  md_sequencer #(.WIDTH(W), .MULT_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op),
    .opa(opa), .opb(opb), .hilo_rd(hilo_rd), .hilo_wr(hilo_wr),
    .md_busy(md_busy), .md_stall(md_stall), .md_done(md_done),
    .md_hi(md_hi), .md_lo(md_lo), .md_dbz(md_dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (md_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("md_hi", 64'(md_hi), 64'(e.hi));
          chk("md_lo", 64'(md_lo), 64'(e.lo));
          chk("md_dbz", 64'(md_dbz), 64'(e.dbz));
        end
      end else begin
        chk("quiet_hilo", {md_hi, md_lo}, 64'd0);
        chk("quiet_dbz", 64'(md_dbz), 64'd0);
      end
    end
  end

  task automatic push_exp(input logic [1:0] op, input logic [W-1:0] ehi, elo, input logic edbz);
    exp_t e;
    e.hi  = ehi;
    e.lo  = elo;
    e.dbz = edbz;
    e.cyc = cyc + 1 + (op[1] ? W : LAT);
    sb.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, b,
                       input logic [W-1:0] ehi, elo, input logic edbz, input bit track);
    issue_valid = 1'b1;
    issue_op    = op;
    opa         = a;
    opb         = b;
    if (track) push_exp(op, ehi, elo, edbz);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic run(input logic [1:0] op, input logic [W-1:0] a, b,
                     input logic [W-1:0] ehi, elo, input logic edbz);
    issue(op, a, b, ehi, elo, edbz, 1'b1);
    wait_cycles((op[1] ? W : LAT) + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wait_cycles(3);
    rst = 1'b0;
    hilo_rd = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(md_busy), 64'd0);
    chk("reset_stall", 64'(md_stall), 64'd0);
    chk("reset_done", 64'(md_done), 64'd0);
    @(posedge clk);
    #1;
    hilo_rd = 1'b0;

    run(MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run(MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run(MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run(MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
    run(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);
    run(MD_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1);
    run(MD_DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);
    run(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);

    // mfhi waiting behind a mult, then a second mult issued in the DONE cycle.
    issue(MD_MULT, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b1);
    hilo_rd = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      chk("stall_while_busy", 64'(md_stall), 64'd1);
      @(posedge clk);
      #1;
    end
    issue_valid = 1'b1;
    issue_op    = MD_MULTU;
    opa         = 32'h00010000;
    opb         = 32'h00010000;
    push_exp(MD_MULTU, 32'd1, 32'd0, 1'b0);
    @(negedge clk);
    chk("stall_in_done", 64'(md_stall), 64'd0);
    chk("busy_in_done", 64'(md_busy), 64'd0);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    hilo_rd     = 1'b0;
    @(negedge clk);
    chk("second_op_busy", 64'(md_busy), 64'd1);
    wait_cycles(LAT + 1);

    // Reset in the middle of a divide: the aborted op must never strobe.
    issue(MD_DIV, 32'd100, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_cycles(9);
    hilo_wr = 1'b1;
    @(negedge clk);
    chk("stall_hilo_wr", 64'(md_stall), 64'd1);
    chk("busy_mid_div", 64'(md_busy), 64'd1);
    rst     = 1'b1;
    hilo_wr = 1'b0;
    hilo_rd = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("busy_after_rst", 64'(md_busy), 64'd0);
    chk("stall_after_rst", 64'(md_stall), 64'd0);
    @(posedge clk);
    #1;
    hilo_rd = 1'b0;
    wait_cycles(40);
    run(MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0);

    wait_cycles(3);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
